// File: rtl/seq_bin2bcd_converter.sv
// rtl/seq_bin2bcd_converter.sv - sequential double-dabble binary-to-BCD converter, one bit per clock (optional LEADING_ZERO_BLANK_EN)
module seq_bin2bcd_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (BIN_W > 2) ? $clog2(BIN_W) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            finish;
    logic            last;

    logic [BIN_W-1:0] sreg;
    logic [BW-1:0]    scr;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;

    logic [BW-1:0]    scr_adj;
    logic [BW-1:0]    scr_shift;
    logic [BIN_W-1:0] sreg_shift;
    logic             carry_out;
    logic             ovf_fin;
    logic [BW-1:0]    nines;
    logic [BW-1:0]    result;

    assign busy = (state == SHIFT);
    assign last = (cnt == '0);

    // Add-3 correction per digit (no inter-digit carry), then shift the combined register left
    always_comb begin
        scr_adj = '0;
        nines   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            scr_adj[4*k +: 4] = (scr[4*k +: 4] > 4'd4) ? (scr[4*k +: 4] + 4'd3) : scr[4*k +: 4];
            nines[4*k +: 4]   = 4'h9;
        end
        {scr_shift, sreg_shift} = {scr_adj, sreg} << 1;
        carry_out = scr_adj[BW-1];
        ovf_fin   = ovf_acc | carry_out | (scr_shift[BW-1 -: 4] > 4'd9);
        result    = ovf_fin ? nines : scr_shift;
    end

    // Next-state logic: accept start only in IDLE, return to IDLE after the last shift
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand capture, shifting, and sticky overflow from bits lost off the top digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            scr     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (load) begin
            sreg    <= bin;
            scr     <= '0;
            cnt     <= CW'(BIN_W - 1);
            ovf_acc <= 1'b0;
        end else if (state == SHIFT) begin
            sreg    <= sreg_shift;
            scr     <= scr_shift;
            cnt     <= cnt - CW'(1);
            ovf_acc <= ovf_acc | carry_out;
        end
    end

    // Result registers: updated only on the finishing edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                bcd      <= result;
                overflow <= ovf_fin;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;

    // Leading-zero mask: digit k blanks when it and every higher digit is zero; digit 0 always shown
    always_comb begin
        logic zero_above;
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above & (result[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_above;
        end
    end

    // Mask is registered alongside bcd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (finish) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule
